// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter with a bounded exclusive lock, sequencing
// single-bit JK commands (hold/clear/set/toggle) into a WIDTH-bit state bank.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_ARB     | round-robin search from ptr; winner gets ready
// ST_LOCKED  | only owner may be accepted; ptr frozen; lock_cnt runs every cycle
module jk_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int IDXW     = $clog2(WIDTH),
  parameter int LOCK_MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*IDXW-1:0]   req_idx,
  input  logic [NREQ*2-1:0]      req_jk,
  input  logic [NREQ-1:0]        req_lock,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_bar,
  output logic                   done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic                   locked
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(LOCK_MAX - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic             locked_q, locked_d;

  logic             win_found;
  logic [IDW-1:0]   winner;
  logic             hs;
  logic [IDW-1:0]   hs_id;
  logic [IDXW-1:0]  sel_idx;
  logic [1:0]       sel_jk;
  logic             sel_lock;

  // Round-robin search: first valid requester at or after ptr, wrapping upward.
  always_comb begin
    win_found = 1'b0;
    winner    = ptr_q;
    for (int off = 0; off < NREQ; off++) begin
      int cand;
      cand = int'(ptr_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        winner    = IDW'(cand);
      end
    end
  end

  // Ready is one-hot on the arbitration winner, or on the owner while locked.
  always_comb begin
    req_ready = '0;
    if (rst) begin
      if (state_q == ST_ARB) begin
        for (int i = 0; i < NREQ; i++)
          req_ready[i] = win_found && (IDW'(i) == winner);
      end else begin
        for (int i = 0; i < NREQ; i++)
          req_ready[i] = req_valid[i] && (IDW'(i) == owner_q);
      end
    end
  end

  // Pick the accepted requester's command fields.
  always_comb begin
    hs       = |(req_valid & req_ready);
    hs_id    = (state_q == ST_LOCKED) ? owner_q : winner;
    sel_idx  = '0;
    sel_jk   = 2'b00;
    sel_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == hs_id) begin
        sel_idx  = req_idx[i*IDXW +: IDXW];
        sel_jk   = req_jk[i*2 +: 2];
        sel_lock = req_lock[i];
      end
    end
  end

  // Apply the JK op to the addressed bit; an index past the bank matches no bit.
  always_comb begin
    q_d = q_q;
    if (hs) begin
      for (int b = 0; b < WIDTH; b++) begin
        if ({1'b0, sel_idx} == (IDXW+1)'(b)) begin
          case (sel_jk)
            2'b01:   q_d[b] = 1'b0;
            2'b10:   q_d[b] = 1'b1;
            2'b11:   q_d[b] = ~q_q[b];
            default: q_d[b] = q_q[b];
          endcase
        end
      end
    end
  end

  // Next-state: pointer advance, lock entry/exit and the forced-release timer.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    done_d     = hs;
    done_id_d  = hs ? hs_id : done_id_q;
    case (state_q)
      ST_ARB: begin
        if (hs) begin
          ptr_d = (winner == ID_LAST) ? '0 : winner + IDW'(1);
          if (sel_lock) begin
            state_d    = ST_LOCKED;
            owner_d    = winner;
            lock_cnt_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        lock_cnt_d = lock_cnt_q + CW'(1);
        if (lock_cnt_q == CNT_LAST) begin
          // Timeout wins over a renewed lock request; the command still applies.
          state_d    = ST_ARB;
          lock_cnt_d = '0;
        end else if (hs && !sel_lock) begin
          state_d    = ST_ARB;
          lock_cnt_d = '0;
        end
      end
      default: state_d = ST_ARB;
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  // All state registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_ARB;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      q_q        <= '0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      q_q        <= q_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      locked_q   <= locked_d;
    end
  end

  assign q       = q_q;
  assign q_bar   = ~q_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign locked  = locked_q;

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Shared-access controller for a bank of WIDTH JK-style state bits. Up to NREQ requesters issue single-bit JK commands (hold/clear/set/toggle) through valid/ready handshakes. A round-robin arbiter with an optional bounded lock applies at most one command per cycle. It sits between control agents and the bank, and is the single point that sequences all bank updates.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: number of JK bits in the bank (2..64).
- IDXW, $clog2(WIDTH): bit-index width (derived).
- LOCK_MAX, 16: maximum cycles a requester may hold the lock (≥1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_idx  in  NREQ*IDXW  target bit index; requester i in slice [i*IDXW +: IDXW].
- req_jk  in  NREQ*2  {j,k} op; requester i in slice [i*2 +: 2].
- req_lock  in  NREQ  request/keep exclusive ownership after this command.
- q  out  WIDTH  bank state.
- q_bar  out  WIDTH  ~q, always.
- done  out  1  registered pulse, one cycle after each accepted command.
- done_id  out  $clog2(NREQ)  requester of the command reported by done.
- locked  out  1  high while in LOCKED state.

## Operation
- JK ops on q[idx]: 00 hold, 01 clear, 10 set, 11 toggle. Other bits are unchanged.
- An out-of-range idx (≥ WIDTH) is accepted and acts as hold. done still pulses.
- State ARB: the winner is the first valid requester at or after the pointer ptr, searching upward with wrap. req_ready is one-hot on the winner, combinational from req_valid/state/ptr.
- Handshake = req_valid[i] & req_ready[i].
- On a handshake in ARB, ptr <= winner+1 mod NREQ.
  - If req_lock[winner] = 1: go to LOCKED, owner <= winner, lock_cnt <= 0.
- State LOCKED: only the owner may get ready. All other requesters are stalled. ptr is frozen.
  - Owner handshake with req_lock = 0: command applied, return to ARB.
  - Owner handshake with req_lock = 1: stay LOCKED.
- lock_cnt increments every cycle in LOCKED. This includes cycles where the owner is idle.
- When lock_cnt = LOCK_MAX-1, the lock is forcibly released.
  - A handshake in that cycle is still applied.
  - The next state is ARB regardless of req_lock.
- Reset (rst = 0 at an edge):
  - q = 0, q_bar = all ones, done = 0, done_id = 0, locked = 0, ptr = 0, state ARB.
  - req_ready = 0 while rst is low.
- Reset mid-lock or mid-command abandons the lock. Commands presented in the reset cycle are dropped.

## Timing
- Command latency 1: q updates at the edge that completes the handshake. done and done_id are valid in the following cycle.
- Throughput: one command per cycle. Back-to-back handshakes from the same or different requesters are allowed.
- Requesters must hold req_valid, req_idx, req_jk and req_lock stable until accepted. Ready may drop without a handshake, e.g. when lock is taken by another requester.
- No combinational path from req_* to q. Only req_ready is combinational.
- locked is registered and reflects the current state.
- Fairness: in ARB with all requesters continuously valid and unlocked, each requester is granted exactly once every NREQ cycles.

## Test plan
- Reset: hold rst = 0 for 2 cycles with all req_valid = 1 -> req_ready = 0, q = 0x00, q_bar = 0xFF, done = 0. After release, requester 0 is granted first.
- Ops: requester 0 only, idx 3, ops 10, 11, 11, 01, 00 on consecutive cycles -> q[3] = 1, 0, 1, 0, 0 after each edge. done pulses 5 times with done_id = 0.
- Round-robin: all 4 requesters valid continuously with set on idx 0..3 -> grants in order 0, 1, 2, 3. q = 0x0F after 4 cycles. Order repeats 0, 1, 2, 3 with continued valid.
- Lock: requester 2 sends 3 commands with req_lock = 1, 1, 0 while others are valid -> only requester 2 is ready for those 3 handshakes, locked = 1 during them. Next grant goes to requester 3.
- Lock timeout: LOCK_MAX = 4, requester 1 locks then deasserts valid -> locked drops after 4 cycles in LOCKED. Requester 2 is then granted.
- Boundary: idx = WIDTH (when WIDTH < 2^IDXW) with op 10 -> q unchanged, done pulses. Reset asserted during lock -> locked = 0 and q = 0 after the edge.
